// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 64-bit memory port among four requesters.
// Optional WAIT-state timeout is built only when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       port_ready,
  input  logic       port_done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       port_valid,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_check
      $error("mem_port_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end
  endgenerate

  logic [1:0] state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       pv_q, pv_d;
  logic       busy_q, busy_d;
  logic       terr_q, terr_d;

  logic       win_found;
  logic [1:0] win_idx;

  // Search order starts just after the last requester served and wraps to it last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      if (!win_found && req[last_q + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = last_q + 2'(k);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    pv_d    = pv_q;
    busy_d  = busy_q;
    terr_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANT;
          gnt_d   = 4'b0001 << win_idx;
          sel_d   = win_idx;
          pv_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_GRANT: begin
        if (port_ready && port_done) begin
          state_d = S_IDLE;
          last_d  = sel_q;
          gnt_d   = 4'b0000;
          pv_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (port_ready) begin
          state_d = S_WAIT;
          pv_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end else if (!req[sel_q]) begin
          // Withdrawal does not count as service, so priority is left alone.
          state_d = S_IDLE;
          gnt_d   = 4'b0000;
          pv_d    = 1'b0;
          busy_d  = 1'b0;
        end
      end
      S_WAIT: begin
        if (port_done) begin
          state_d = S_IDLE;
          last_d  = sel_q;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = S_IDLE;
          last_d  = sel_q;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          terr_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
        pv_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 2'd3;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      pv_q    <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      pv_q    <= pv_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign gnt        = gnt_q;
  assign sel        = sel_q;
  assign port_valid = pv_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       port_ready;
  logic       port_done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       port_valid;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .port_ready(port_ready),
    .port_done(port_done), .gnt(gnt), .sel(sel), .port_valid(port_valid),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the port, whether the port has accepted, and
  // the index last served.
  bit m_busy, m_acc, m_terr;
  int m_owner, m_last, m_sel, m_wait;

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_terr = 0;
    m_owner = 0; m_last = 3; m_sel = 0; m_wait = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic rdy, input logic dn);
    m_terr = 0;
    if (!m_busy) begin
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (m_last + k) % 4;
        if (!m_busy && r[idx]) begin
          m_busy = 1; m_acc = 0; m_owner = idx; m_sel = idx;
        end
      end
    end else if (!m_acc) begin
      if (rdy && dn) begin
        m_last = m_owner; m_busy = 0;
      end else if (rdy) begin
        m_acc = 1; m_wait = 0;
      end else if (!r[m_owner]) begin
        m_busy = 0;
      end
    end else begin
      if (dn) begin
        m_last = m_owner; m_busy = 0;
      end else begin
        m_wait++;
`ifdef ARB_TIMEOUT_EN
        if (m_wait == TO) begin
          m_last = m_owner; m_busy = 0; m_terr = 1;
        end
`endif
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    check({tag, ".gnt"},  32'(gnt), 32'(eg));
    check({tag, ".sel"},  32'(sel), 32'(m_sel));
    check({tag, ".pv"},   32'(port_valid), 32'(m_busy && !m_acc));
    check({tag, ".busy"}, 32'(busy), 32'(m_busy));
    check({tag, ".terr"}, 32'(timeout_err), 32'(m_terr));
  endtask

  // Called at a falling edge: drive, clock once, advance the model, sample at next falling edge.
  task automatic cycle(input logic [3:0] r, input logic rdy, input logic dn);
    req = r; port_ready = rdy; port_done = dn;
    @(posedge clk);
    model_step(r, rdy, dn);
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] r;
    logic       rdy;
    logic       dn;
    logic [3:0] g;
    logic [1:0] s;
    logic       pv;
    logic       b;
  } vec_t;

  vec_t tbl[18];
  int   pulses;
  int   pulse_at;

  initial begin
    tbl[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b1};
    tbl[2]  = '{4'b1111, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[4]  = '{4'b1111, 1'b1, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
    tbl[5]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[6]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0, 1'b1};
    tbl[7]  = '{4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0, 1'b1};
    tbl[8]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    tbl[9]  = '{4'b0101, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[10] = '{4'b0101, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[11] = '{4'b0101, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[12] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0};
    tbl[13] = '{4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[14] = '{4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[15] = '{4'b0000, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0, 1'b1};
    tbl[16] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    tbl[17] = '{4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1};

    rst_n = 1'b0; req = 4'b1111; port_ready = 1'b0; port_done = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst.gnt",  32'(gnt), 32'h0);
    check("rst.sel",  32'(sel), 32'h0);
    check("rst.pv",   32'(port_valid), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.terr", 32'(timeout_err), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].r, tbl[i].rdy, tbl[i].dn);
      check($sformatf("vec%0d.gnt", i),  32'(gnt), 32'(tbl[i].g));
      check($sformatf("vec%0d.sel", i),  32'(sel), 32'(tbl[i].s));
      check($sformatf("vec%0d.pv", i),   32'(port_valid), 32'(tbl[i].pv));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(tbl[i].b));
      check($sformatf("vec%0d.terr", i), 32'(timeout_err), 32'h0);
    end

    // Asynchronous reset while the port is mid-transaction.
    cycle(4'b1000, 1'b1, 1'b0);
    check("prewait.busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.gnt",  32'(gnt), 32'h0);
    check("arst.busy", 32'(busy), 32'h0);
    check("arst.pv",   32'(port_valid), 32'h0);
    check("arst.sel",  32'(sel), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1111, 1'b0, 1'b0);
    check("arst_restart.gnt", 32'(gnt), 32'h1);
    check_model("arst_restart");
    cycle(4'b1111, 1'b1, 1'b1);
    check_model("arst_done");

    // Stalled port: no port_done after acceptance.
    cycle(4'b0010, 1'b0, 1'b0);
    check("stall.gnt", 32'(gnt), 32'h2);
    cycle(4'b0010, 1'b1, 1'b0);
    pulses = 0; pulse_at = -1;
    for (int i = 1; i <= 6; i++) begin
      cycle(4'b0110, 1'b0, 1'b0);
      check_model($sformatf("stall%0d", i));
      if (timeout_err === 1'b1) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
      end
`ifdef ARB_TIMEOUT_EN
      if (i == 5) check("to_next.gnt", 32'(gnt), 32'h4);
`endif
    end
`ifdef ARB_TIMEOUT_EN
    check("to.pulses", 32'(pulses), 32'd1);
    check("to.pulse_at", 32'(pulse_at), 32'(TO));
`else
    check("noto.pulses", 32'(pulses), 32'd0);
    check("noto.busy", 32'(busy), 32'h1);
`endif

    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom_range(0, 15)), ($urandom % 3) == 0, ($urandom % 3) == 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
